// File: rtl/snake_body.sv
// snake_body: snake head/length/direction-history state with a continuous head-to-tail segment stream and collision detection.
module snake_body #(
  parameter int GAME_WIDTH  = 18,
  parameter int GAME_HEIGHT = 13,
  parameter int MAX_LEN     = 32,
  parameter int INIT_X      = 4,
  parameter int INIT_Y      = 7,
  parameter int INIT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       step,
  input  logic [1:0] move_dir,
  input  logic       grow,
  output logic [4:0] snake_head_x,
  output logic [3:0] snake_head_y,
  output logic [4:0] snake_x,
  output logic [3:0] snake_y,
  output logic [1:0] snake_dir,
  output logic       snake_first,
  output logic       snake_last,
  output logic       snake_valid,
  output logic [5:0] length,
  output logic       collision
);
  localparam int KW = $clog2(MAX_LEN);
  typedef struct packed {
    logic [4:0]               hx;
    logic [3:0]               hy;
    logic [5:0]               len;
    logic [1:0]               heading;
    logic [MAX_LEN-1:0][1:0]  dirs;
    logic                     coll;
    logic                     pend;
    logic                     pgrow;
    logic [1:0]               pdir;
    logic [KW-1:0]            k;
    logic [4:0]               px;
    logic [3:0]               py;
    logic                     chk;
    logic                     hit;
    logic [4:0]               ox;
    logic [3:0]               oy;
    logic [1:0]               odir;
    logic                     ofirst;
    logic                     olast;
    logic                     ovalid;
  } st_t;
  localparam st_t S_INIT = '{hx: 5'(INIT_X), hy: 4'(INIT_Y), len: 6'(INIT_LEN), heading: 2'd3,
                            dirs: {MAX_LEN{2'd2}}, px: 5'(INIT_X), py: 4'(INIT_Y), default: '0};
  function automatic logic [1:0] opp(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction
  function automatic logic [8:0] adv(input logic [4:0] x, input logic [3:0] y, input logic [1:0] d);
    return d == 2'd0 ? {x, y - 4'd1} : d == 2'd1 ? {x, y + 4'd1} : d == 2'd2 ? {x - 5'd1, y} : {x + 5'd1, y};
  endfunction
  st_t s_q, s_d;
  logic tail, pend, grw, oob, hit_now, self_c, wall, do_move;
  logic [1:0] req, mv_d;
  logic [4:0] nx;
  logic [3:0] ny;
  assign tail    = 6'(s_q.k) == s_q.len - 6'd1;
  assign pend    = s_q.pend | step;
  assign req     = step ? move_dir : s_q.pdir;
  assign grw     = step ? grow : s_q.pgrow;
  assign mv_d    = req == opp(s_q.heading) ? s_q.heading : req;
  assign {nx, ny} = adv(s_q.hx, s_q.hy, mv_d);
  assign oob     = nx == '0 || nx > 5'(GAME_WIDTH) || ny == '0 || ny > 4'(GAME_HEIGHT);
  assign hit_now = s_q.k != '0 && s_q.px == s_q.hx && s_q.py == s_q.hy;
  // a self hit found in this walk outranks any move waiting at the same tail
  assign self_c  = tail && s_q.chk && (s_q.hit || hit_now);
  assign wall    = tail && pend && !s_q.coll && !self_c && oob;
  assign do_move = tail && pend && !s_q.coll && !self_c && !oob;
  always_comb begin
    s_d = s_q;
    s_d.ox = s_q.px;
    s_d.oy = s_q.py;
    s_d.odir = s_q.dirs[s_q.k];
    s_d.ofirst = s_q.k == '0;
    s_d.olast = tail;
    s_d.ovalid = 1'b1;
    s_d.hit = s_q.hit | hit_now;
    if (step) begin
      s_d.pend = 1'b1;
      s_d.pdir = move_dir;
      s_d.pgrow = grow;
    end
    if (tail) begin
      s_d.k = '0;
      s_d.px = s_q.hx;
      s_d.py = s_q.hy;
      s_d.hit = 1'b0;
      s_d.pend = 1'b0;
      s_d.chk = do_move;
      s_d.coll = s_q.coll | self_c | wall;
      if (do_move) begin
        s_d.hx = nx;
        s_d.hy = ny;
        s_d.px = nx;
        s_d.py = ny;
        s_d.heading = mv_d;
        s_d.dirs = {s_q.dirs[MAX_LEN-2:0], opp(mv_d)};
        s_d.len = s_q.len + 6'(grw && s_q.len < 6'(MAX_LEN));
      end
    end else begin
      s_d.k = s_q.k + 1'b1;
      {s_d.px, s_d.py} = adv(s_q.px, s_q.py, s_q.dirs[s_q.k]);
    end
    if (restart) s_d = S_INIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= S_INIT;
    else s_q <= s_d;
  assign snake_head_x = s_q.hx;
  assign snake_head_y = s_q.hy;
  assign snake_x      = s_q.ox;
  assign snake_y      = s_q.oy;
  assign snake_dir    = s_q.odir;
  assign snake_first  = s_q.ofirst;
  assign snake_last   = s_q.olast;
  assign snake_valid  = s_q.ovalid;
  assign length       = s_q.len;
  assign collision    = s_q.coll;
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: randomized and directed checks of snake_body against a position-trail reference model.
module tb_snake_body;
  logic clk = 0, rst = 0, restart = 0, step = 0, grow = 0;
  logic [1:0] move_dir = 0;
  logic [4:0] snake_head_x, snake_x;
  logic [3:0] snake_head_y, snake_y;
  logic [1:0] snake_dir;
  logic snake_first, snake_last, snake_valid, collision;
  logic [5:0] length;
  int errors = 0, checks = 0;
  int tx[$], ty[$];
  int m_len, m_hd, m_k, m_pdir, m_ox, m_oy, m_odir;
  bit m_coll, m_pend, m_pgrow, m_chk, m_of, m_ol, m_ov;
  logic [29:0] obs;
  always #5 clk = ~clk;
  snake_body dut (.clk(clk), .rst(rst), .restart(restart), .step(step), .move_dir(move_dir), .grow(grow),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y), .snake_x(snake_x), .snake_y(snake_y),
    .snake_dir(snake_dir), .snake_first(snake_first), .snake_last(snake_last), .snake_valid(snake_valid),
    .length(length), .collision(collision));
  assign obs = {snake_head_x, snake_head_y, snake_x, snake_y, snake_dir, snake_first, snake_last,
                snake_valid, length, collision};
  function automatic logic [29:0] expv();
    return {5'(tx[0]), 4'(ty[0]), 5'(m_ox), 4'(m_oy), 2'(m_odir), m_of, m_ol, m_ov, 6'(m_len), m_coll};
  endfunction
  // Direction of travel from trail entry k to the next (older) one.
  function automatic int dirto(int k);
    if (ty[k+1] < ty[k]) return 0;
    if (ty[k+1] > ty[k]) return 1;
    if (tx[k+1] < tx[k]) return 2;
    return 3;
  endfunction
  task automatic m_init();
    tx.delete(); ty.delete();
    for (int i = 0; i <= 32; i++) begin tx.push_back(4 - i); ty.push_back(7); end
    m_len = 3; m_hd = 3; m_k = 0; m_pdir = 0; m_coll = 0; m_pend = 0; m_pgrow = 0; m_chk = 0;
    m_ox = 0; m_oy = 0; m_odir = 0; m_of = 0; m_ol = 0; m_ov = 0;
  endtask
  task automatic m_edge(bit st, int md, bit gr, bit rs);
    bit hit, pend, g, moved;
    int d, nx, ny;
    if (rs) begin m_init(); return; end
    m_ox = tx[m_k]; m_oy = ty[m_k]; m_odir = dirto(m_k);
    m_of = m_k == 0; m_ol = m_k == m_len - 1; m_ov = 1;
    pend = m_pend || st; d = st ? md : m_pdir; g = st ? gr : m_pgrow;
    m_pend = pend; m_pdir = d; m_pgrow = g;
    if (m_k != m_len - 1) begin m_k++; return; end
    hit = 0; moved = 0;
    if (m_chk) for (int j = 1; j < m_len; j++) if (tx[j] == tx[0] && ty[j] == ty[0]) hit = 1;
    if (hit) m_coll = 1;
    else if (pend && !m_coll) begin
      if ((d ^ 1) == m_hd) d = m_hd;
      nx = tx[0] + (d == 2 ? -1 : d == 3 ? 1 : 0);
      ny = ty[0] + (d == 0 ? -1 : d == 1 ? 1 : 0);
      if (nx < 1 || nx > 18 || ny < 1 || ny > 13) m_coll = 1;
      else begin
        tx.push_front(nx); ty.push_front(ny);
        if (tx.size() > 33) begin tx.pop_back(); ty.pop_back(); end
        m_hd = d;
        if (g && m_len < 32) m_len++;
        moved = 1;
      end
    end
    m_chk = moved; m_pend = 0; m_k = 0;
  endtask
  task automatic tick(bit st, int md, bit gr, bit rs);
    step = st; move_dir = 2'(md); grow = gr; restart = rs;
    @(posedge clk);
    m_edge(st, md, gr, rs);
    #1;
    step = 0; grow = 0; restart = 0;
  endtask
  task automatic test_reset();
    int xs[3] = '{4, 3, 2};
    m_init();
    #2 rst = 1;
    #1;
    checks++; if (obs !== expv()) begin errors++; $display("FAIL reset_async got=%h exp=%h", obs, expv()); end
    @(posedge clk); @(posedge clk); #1 rst = 0;
    checks++; if (obs !== expv()) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs, expv()); end
    for (int j = 0; j < 6; j++) begin
      tick(0, 0, 0, 0);
      checks++; if (obs !== expv()) begin errors++; $display("FAIL reset_walk got=%h exp=%h", obs, expv()); end
      checks++;
      if ({snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid} !==
          {5'(xs[j%3]), 4'd7, 2'd2, j % 3 == 0, j % 3 == 2, 1'b1}) begin
        errors++; $display("FAIL reset_table j=%0d got=%0d,%0d,%0d,%b%b%b", j, snake_x, snake_y, snake_dir,
                           snake_first, snake_last, snake_valid);
      end
    end
  endtask
  task automatic test_move_down();
    tick(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0);
      checks++; if (obs !== expv()) begin errors++; $display("FAIL down_stream got=%h exp=%h", obs, expv()); end
    end
    checks++;
    if ({snake_head_x, snake_head_y, length} !== {5'd4, 4'd8, 6'd3}) begin
      errors++; $display("FAIL down_head got=(%0d,%0d) len=%0d exp=(4,8) len=3", snake_head_x, snake_head_y, length);
    end
  endtask
  task automatic test_grow();
    int d, n;
    tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    tick(1, 3, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0);
      checks++; if (obs !== expv()) begin errors++; $display("FAIL grow_first got=%h exp=%h", obs, expv()); end
    end
    checks++;
    if ({snake_head_x, snake_head_y, length} !== {5'd5, 4'd7, 6'd4}) begin
      errors++; $display("FAIL grow_head got=(%0d,%0d) len=%0d exp=(5,7) len=4", snake_head_x, snake_head_y, length);
    end
    for (int s = 0; s < 30; s++) begin
      d = m_hd == 1 ? (tx[0] >= 17 ? 2 : 3) : m_hd == 3 ? (tx[0] < 17 ? 3 : 1) : (tx[0] > 2 ? 2 : 1);
      tick(1, d, 1, 0);
      n = m_len + 2;
      for (int i = 0; i < n; i++) begin
        tick(0, 0, 0, 0);
        checks++; if (obs !== expv()) begin errors++; $display("FAIL grow_stream got=%h exp=%h", obs, expv()); end
      end
      if (s == 28) begin
        checks++; if (length !== 6'd32) begin errors++; $display("FAIL grow_max got=%0d exp=32", length); end
      end
    end
    checks++; if (length !== 6'd32 || collision !== 1'b0) begin
      errors++; $display("FAIL grow_sat got len=%0d coll=%b exp len=32 coll=0", length, collision);
    end
  endtask
  task automatic test_reversal();
    tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    tick(1, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0);
      checks++; if (obs !== expv()) begin errors++; $display("FAIL rev_stream got=%h exp=%h", obs, expv()); end
    end
    checks++;
    if ({snake_head_x, snake_head_y} !== {5'd5, 4'd7}) begin
      errors++; $display("FAIL rev_head got=(%0d,%0d) exp=(5,7)", snake_head_x, snake_head_y);
    end
  endtask
  task automatic test_wall();
    tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    for (int s = 0; s < 16; s++) begin
      tick(1, s < 15 ? 3 : 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
        tick(0, 0, 0, 0);
        checks++; if (obs !== expv()) begin errors++; $display("FAIL wall_stream got=%h exp=%h", obs, expv()); end
      end
      if (s == 13) begin
        checks++; if ({snake_head_x, collision} !== {5'd18, 1'b0}) begin
          errors++; $display("FAIL wall_edge got x=%0d coll=%b exp x=18 coll=0", snake_head_x, collision);
        end
      end
    end
    checks++;
    if ({snake_head_x, snake_head_y, collision} !== {5'd18, 4'd7, 1'b1}) begin
      errors++; $display("FAIL wall_hit got=(%0d,%0d) coll=%b exp=(18,7) coll=1", snake_head_x, snake_head_y, collision);
    end
    tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    checks++;
    if ({snake_head_x, snake_head_y, length, collision} !== {5'd4, 4'd7, 6'd3, 1'b0}) begin
      errors++; $display("FAIL wall_restart got=(%0d,%0d) len=%0d coll=%b", snake_head_x, snake_head_y, length, collision);
    end
  endtask
  task automatic test_self();
    int mv[5] = '{3, 3, 1, 2, 0};
    tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    for (int s = 0; s < 5; s++) begin
      tick(1, mv[s], s < 2, 0);
      for (int i = 0; i < 12; i++) begin
        tick(0, 0, 0, 0);
        checks++; if (obs !== expv()) begin errors++; $display("FAIL self_stream got=%h exp=%h", obs, expv()); end
      end
    end
    checks++;
    if ({snake_head_x, snake_head_y, length, collision} !== {5'd5, 4'd7, 6'd5, 1'b1}) begin
      errors++; $display("FAIL self_hit got=(%0d,%0d) len=%0d coll=%b exp=(5,7) len=5 coll=1",
                         snake_head_x, snake_head_y, length, collision);
    end
    tick(0, 0, 0, 1); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    checks++; if (snake_x !== 5'd3 || snake_first !== 1'b0) begin
      errors++; $display("FAIL abort_k1 got x=%0d first=%b exp x=3 first=0", snake_x, snake_first);
    end
    tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    checks++;
    if ({snake_x, snake_y, snake_first, snake_valid} !== {5'd4, 4'd7, 1'b1, 1'b1}) begin
      errors++; $display("FAIL abort_restart got=(%0d,%0d) first=%b valid=%b exp=(4,7) 1 1",
                         snake_x, snake_y, snake_first, snake_valid);
    end
    tick(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0);
      checks++; if (obs !== expv()) begin errors++; $display("FAIL steprst_stream got=%h exp=%h", obs, expv()); end
    end
    checks++; if ({snake_head_x, snake_head_y, length} !== {5'd4, 4'd7, 6'd3}) begin
      errors++; $display("FAIL steprst_head got=(%0d,%0d) len=%0d exp=(4,7) len=3", snake_head_x, snake_head_y, length);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 119) == 0);
      checks++; if (obs !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_move_down();
    test_grow();
    test_reversal();
    test_wall();
    test_self();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Holds the snake's state: head tile, a per-segment direction history and the current length.
- Advances the snake one tile per game step, with optional growth.
- Continuously streams every body segment, head to tail, one per clock, to the VGA renderer. The renderer consumes these as snake_x/y/dir/first/last/valid and snake_head_x/y.
- Detects wall and self collisions for the game controller.

Parameters:
- GAME_WIDTH, 18, playfield columns; legal x is 1..GAME_WIDTH.
- GAME_HEIGHT, 13, playfield rows; legal y is 1..GAME_HEIGHT.
- MAX_LEN, 32, maximum number of segments; sets the size of the direction shift register.
- INIT_X, 4, head x after reset or restart.
- INIT_Y, 7, head y after reset or restart.
- INIT_LEN, 3, length after reset or restart; must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- restart  in  1  synchronous game restart; same effect as rst
- step  in  1  single-cycle pulse: move one tile
- move_dir  in  2  requested heading: 0=up(-y), 1=down(+y), 2=left(-x), 3=right(+x)
- grow  in  1  sampled with step; length increments on that move
- snake_head_x  out  5  current head column
- snake_head_y  out  4  current head row
- snake_x  out  5  streamed segment column
- snake_y  out  4  streamed segment row
- snake_dir  out  2  direction from streamed segment toward the next segment (toward tail)
- snake_first  out  1  streamed segment is the head
- snake_last  out  1  streamed segment is the tail
- snake_valid  out  1  stream outputs are meaningful
- length  out  6  current segment count
- collision  out  1  sticky wall or self collision

Behaviour:
- Reset and restart values:
  - head = (INIT_X, INIT_Y); length = INIT_LEN; heading = 3 (right).
  - All dir entries = 2, so the body extends left of the head.
  - collision = 0; pending = 0; walk index k = 0; snake_valid = 0.
- Opposite direction: opposite(d) = {d[1], ~d[0]}. 0 and 1 are opposite; 2 and 3 are opposite.
- Stream (walk):
  - A walk is one pass from k = 0 to k = length-1.
  - Walk outputs are registered. snake_valid = 1 every cycle from the first cycle after reset or restart.
  - Cycle k outputs: position p_k, snake_dir = dir[k], first = (k==0), last = (k==length-1).
  - p_0 = head; p_(k+1) = p_k stepped one tile in direction dir[k].
  - After the last segment, k returns to 0 on the next cycle. There is no gap, so the walk period equals length.
- Step handling:
  - A step pulse sets pending. Further pulses while pending is set are merged.
  - grow and move_dir are captured at the pulse. Later pulses overwrite the captured values.
  - The move is applied on the cycle the tail (last=1) is streamed, so every walk is self-consistent.
  - The new head appears on snake_head_x/y and in the next walk starting the following cycle.
  - If collision = 1, no move is ever applied; pending is cleared.
- Move application, with d = captured move_dir:
  - If d == opposite(heading), use d = heading; reversal is ignored.
  - New head = head stepped in d.
  - If the new head would be outside 1..GAME_WIDTH or 1..GAME_HEIGHT: set collision, and leave head, dirs and length unchanged.
  - Otherwise:
    - dir[0] <= opposite(d); dir[i] <= dir[i-1].
    - heading <= d; head <= new head.
    - length <= length+1 if grow and length < MAX_LEN; at MAX_LEN, grow is ignored.
- Self collision:
  - During each walk, compare p_k with head for 1 ≤ k ≤ length-1.
  - A hit is latched and commits to collision at walk end, on the tail cycle.
  - Checking is active only in walks that begin after a move was applied.
- collision stays set until rst or restart.
- restart mid-walk: the walk aborts and state reinitialises. The next cycle streams k = 0 of the initial snake.
- Step and restart in the same cycle: restart wins and pending is cleared.
- Arithmetic: coordinate adds are unsigned, width-limited; bounds are checked before commit, so x and y never wrap.

Test Plan:
- Reset then release → head (4,7), length 3. Stream repeats with period 3:
  - (4,7,dir2,first=1,last=0)
  - (3,7,dir2,0,0)
  - (2,7,dir2,0,1)
- step with move_dir=1, grow=0 → at the next tail cycle head becomes (4,8). Next walk: (4,8,dir0,first), (4,7,dir2), (3,7,last); length stays 3.
- step with move_dir=3, grow=1 → head (5,7), length 4, stream ends at (2,7) with last=1. After 29 more growing steps, length saturates at 32.
- Heading right, step with move_dir=2 → reversal ignored, head moves to (5,7).
- Head at (18,7), step with move_dir=3 → collision=1 at the tail cycle, head stays (18,7). Further steps are ignored; restart clears collision and restores the initial snake.
- Length 5 snake, moves down, left, up from (4,7) → head lands on a body tile. collision=1 at the end of the following walk. Also: pulse restart mid-walk at k=1 → next cycle streams k=0 at (4,7).
